imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes SimpleRisc machine code into the instruction memory read by the pipelined processor's IF stage. It receives a byte stream of header, program words and checksum, assembles 32-bit words, and issues one write per word to instruction memory. While loading, it holds the processor in reset. It releases the processor only after a verified, complete load.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; clears all state next edge
- start  in  1  begin a load; honoured only in IDLE, DONE, ERR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  word to write
- cpu_hold  out  1  processor reset request; low only in DONE
- done  out  1  load verified; sticky
- error  out  1  load failed; sticky
- words_loaded  out  ADDR_W+1  program words written so far

## Operation
- Stream format: header word N (program word count), then N program words, then one checksum word equal to the XOR of the N program words.
- Every word is 4 bytes, MSB first: the first byte lands in bits 31:24.
- A 2-bit byte counter assembles each word. The word completes on the 4th accepted byte, and the counter wraps to 0.
- FSM states:
  - IDLE: byte_ready=0; start goes to HDR.
  - HDR: byte_ready=1; on word completion:
    - N > MAX_WORDS goes to ERR.
    - N == 0 goes to CHK.
    - Otherwise latch N and go to LOAD.
  - LOAD: byte_ready=1; each completed word is written at address words_loaded, words_loaded increments, and the word is XORed into the running checksum. After word N, go to CHK.
  - CHK: byte_ready=1; on word completion, go to DONE if the word equals the running checksum, else ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0.
  - ERR: error=1, cpu_hold=1, byte_ready=0.
- start in DONE or ERR goes to HDR. It clears done, error, words_loaded, the byte counter and the checksum, and raises cpu_hold in the same edge.
- start in HDR, LOAD or CHK is ignored.
- Bytes offered while byte_ready=0 are not consumed. The source must hold them.
- Header and checksum words never produce imem_we.
- Memory contents beyond N are untouched.

## Timing
- Reset values:
  - outputs: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0
  - internal: state=IDLE, byte counter=0, checksum=0
- Reset mid-load aborts with no further imem_we. Memory keeps the words already written.
- byte_ready is a registered function of state.
  - It is already high in the cycle after start is sampled.
  - It drops in the cycle after the final byte of the header (error case), the checksum, or a failing word.
- imem_we, imem_addr and imem_wdata are registered. They are valid for exactly one cycle, the cycle after the edge that accepted the 4th byte of a program word.
- words_loaded updates on that same edge.
- Throughput: one byte per cycle. Back-to-back words give one imem_we every 4 cycles.
- State transitions on a word-completing byte take effect on the same edge as the byte acceptance.
  - The next byte is then accepted under the new state with no bubble.
  - Exception: the transition into DONE/ERR, after which byte_ready is low.
- done/cpu_hold change on the edge accepting the last checksum byte. They are visible the following cycle.
- reset has priority over start. start has priority over nothing else, since no bytes are accepted in IDLE, DONE or ERR.

## Test plan
- Normal load:
  - Stimulus: N=3, words 0x11223344, 0xA0000005, 0xFFFFFFFF, checksum 0x4EDDCCBE.
  - Response: three imem_we pulses at addresses 0,1,2 with those data; done=1; cpu_hold=0; words_loaded=3.
- Checksum mismatch:
  - Stimulus: same stream with checksum 0x00000000.
  - Response: all three writes occur, then error=1, done=0, cpu_hold stays 1.
- Oversize header:
  - Stimulus: N=0x00000401 with ADDR_W=10.
  - Response: error=1 right after the header, no imem_we, byte_ready=0.
- Empty program:
  - Stimulus: N=0, checksum 0.
  - Response: done=1, no imem_we, words_loaded=0.
- Flow control:
  - Stimulus: drive byte_valid with random gaps during the normal-load case.
  - Response: identical writes and result; bytes offered while byte_ready=0 are not lost.
- Reset and restart:
  - Stimulus: assert reset after 2 of 3 words are written.
  - Response: next cycle all outputs are at reset values, with no third write.
  - Then: start followed by a full valid stream gives done=1, with start in DONE relaunching the load and cpu_hold returning to 1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time SimpleRisc program loader.
// Assembles a big-endian byte stream (header N, N program words, XOR checksum)
// into 32-bit words and writes the program words into instruction memory.
// The processor is held in reset until a complete, checksum-verified load.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [1:0]        r_bcnt;
    logic [23:0]       r_shift;
    logic [31:0]       r_csum;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words_loaded;
    logic              r_byte_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic              w_word_done;
    logic              w_start_ok;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_wl_inc;

    // The fourth byte is taken straight from the input so a word completes
    // on the same edge that accepts its last byte.
    assign w_xfer      = i_byte_valid && r_byte_ready;
    assign w_word_done = w_xfer && (r_bcnt == 2'd3);
    assign w_word      = {r_shift, i_byte_data};
    assign w_wl_inc    = r_words_loaded + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = (w_wl_inc == r_n);
    assign w_start_ok  = i_start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: transitions on word completion or on an honoured start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_HDR;
            end
            S_HDR: begin
                if (w_word_done) begin
                    if (w_word > MAX_WORDS)   w_next_state = S_ERR;
                    else if (w_word == 32'd0) w_next_state = S_CHK;
                    else                      w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_word_done && w_last_word) w_next_state = S_CHK;
            end
            S_CHK: begin
                if (w_word_done) begin
                    w_next_state = (w_word == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (i_start) w_next_state = S_HDR;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags follow the next state so
    // they are visible the cycle after the deciding edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bcnt         <= 2'd0;
            r_shift        <= 24'd0;
            r_csum         <= 32'd0;
            r_n            <= '0;
            r_words_loaded <= '0;
            r_byte_ready   <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= 32'd0;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_byte_ready <= (w_next_state == S_HDR) || (w_next_state == S_LOAD) ||
                            (w_next_state == S_CHK);
            r_cpu_hold   <= (w_next_state != S_DONE);
            r_done       <= (w_next_state == S_DONE);
            r_error      <= (w_next_state == S_ERR);

            if (w_start_ok) begin
                r_bcnt         <= 2'd0;
                r_csum         <= 32'd0;
                r_words_loaded <= '0;
            end else if (w_xfer) begin
                r_bcnt  <= r_bcnt + 2'd1;
                r_shift <= {r_shift[15:0], i_byte_data};
                if (w_word_done && (r_state == S_HDR)) begin
                    r_n <= w_word[ADDR_W:0];
                end
                if (w_word_done && (r_state == S_LOAD)) begin
                    r_we           <= 1'b1;
                    r_addr         <= r_words_loaded[ADDR_W-1:0];
                    r_wdata        <= w_word;
                    r_words_loaded <= w_wl_inc;
                    r_csum         <= r_csum ^ w_word;
                end
            end
        end
    end

    assign o_byte_ready   = r_byte_ready;
    assign o_imem_we      = r_we;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = r_wdata;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of directed streams, reset/restart
// sequence, randomized streams against a word-level reference model.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int MAXW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_byte_valid   (byte_valid),
        .i_byte_data    (byte_data),
        .o_byte_ready   (byte_ready),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_hold     (cpu_hold),
        .o_done         (done),
        .o_error        (error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [ADDR_W+31:0] wr_q[$];
    logic [ADDR_W+31:0] exp_q[$];

    // Record every memory write as {addr, data}.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    end

    typedef struct {
        string       name;
        int          len;
        logic [31:0] w[6];
        int          gap;
        int          exp_cons;
        bit          exp_done;
        bit          exp_err;
        int          exp_wl;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_wl", words_loaded, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready", byte_ready, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_done", done, 0);
        chk("start_err", error, 0);
        chk("start_wl", words_loaded, 0);
    endtask

    // Offer the stream byte by byte; gives up on a byte after 16 idle cycles.
    task automatic send_stream(input logic [31:0] words[$], input int gap_pct,
                               output int consumed, output int ncyc);
        int unsigned n;
        logic [31:0] wv;
        bit acc;
        bit rdy;
        int waited;
        n = words[0];
        consumed = 0;
        ncyc = 0;
        for (int i = 0; i < words.size(); i++) begin
            wv = words[i];
            for (int b = 0; b < 4; b++) begin
                if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                    byte_valid = 1'b0;
                    byte_data  = 8'($urandom);
                    repeat ($urandom_range(3, 1)) @(posedge clk);
                    #1;
                end
                byte_valid = 1'b1;
                byte_data  = wv[31-8*b -: 8];
                acc = 1'b0;
                waited = 0;
                while (!acc && waited < 16) begin
                    @(negedge clk);
                    rdy = byte_ready;
                    @(posedge clk); #1;
                    ncyc++;
                    if (rdy) acc = 1'b1;
                    else waited++;
                end
                if (!acc) begin
                    byte_valid = 1'b0;
                    return;
                end
                consumed++;
                if (b == 3) begin
                    if (i >= 1 && n <= MAXW && i <= n) begin
                        chk("wr_strobe", imem_we, 1);
                        chk("wr_addr", imem_addr, i - 1);
                        chk("wr_data", imem_wdata, wv);
                    end else begin
                        chk("no_wr_strobe", imem_we, 0);
                    end
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    // Word-level reference: what a correct loader writes and concludes.
    task automatic model(input logic [31:0] q[$], output int cons, output bit d,
                         output bit e, output int wl);
        logic [31:0] cs;
        int unsigned n;
        n = q[0];
        exp_q.delete();
        d = 1'b0;
        e = 1'b0;
        if (n > MAXW) begin
            cons = 4;
            e = 1'b1;
            wl = 0;
            return;
        end
        cs = 32'd0;
        for (int k = 1; k <= int'(n); k++) begin
            exp_q.push_back({ADDR_W'(k - 1), q[k]});
            cs ^= q[k];
        end
        wl = int'(n);
        cons = 4 * (int'(n) + 2);
        if (q[n + 1] == cs) d = 1'b1;
        else e = 1'b1;
    endtask

    task automatic run(input logic [31:0] words[$], input int gap, input int exp_cons,
                       input bit ed, input bit ee, input int ewl);
        int cons;
        int ncyc;
        int m;
        wr_q.delete();
        do_start();
        send_stream(words, gap, cons, ncyc);
        if (gap == 0 && cons == 4 * words.size()) chk("throughput", ncyc, cons);
        repeat (2) @(posedge clk);
        #1;
        chk("consumed", cons, exp_cons);
        chk("done", done, ed);
        chk("error", error, ee);
        chk("cpu_hold", cpu_hold, !ed);
        chk("ready_low", byte_ready, 0);
        chk("words_loaded", words_loaded, ewl);
        chk("n_writes", wr_q.size(), exp_q.size());
        m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) chk("write", wr_q[k], exp_q[k]);
    endtask

    initial begin
        logic [31:0] q[$];
        int cons, ncyc, wl;
        bit d, e;

        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;

        vecs[0] = '{"normal", 5, '{32'd3, 32'h11223344, 32'hA0000005, 32'hFFFFFFFF, 32'h4EDDCCBE, 32'd0}, 0, 20, 1, 0, 3};
        vecs[1] = '{"bad_cksum", 5, '{32'd3, 32'h11223344, 32'hA0000005, 32'hFFFFFFFF, 32'h00000000, 32'd0}, 0, 20, 0, 1, 3};
        vecs[2] = '{"oversize", 2, '{32'h00000401, 32'h12345678, 32'd0, 32'd0, 32'd0, 32'd0}, 0, 4, 0, 1, 0};
        vecs[3] = '{"empty", 2, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0, 8, 1, 0, 0};
        vecs[4] = '{"one_word", 3, '{32'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0}, 0, 12, 1, 0, 1};
        vecs[5] = '{"flow_ctl", 5, '{32'd3, 32'h11223344, 32'hA0000005, 32'hFFFFFFFF, 32'h4EDDCCBE, 32'd0}, 40, 20, 1, 0, 3};

        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int k = 0; k < vecs[v].len; k++) q.push_back(vecs[v].w[k]);
            exp_q.delete();
            for (int k = 0; k < vecs[v].exp_wl; k++) exp_q.push_back({ADDR_W'(k), vecs[v].w[k + 1]});
            run(q, vecs[v].gap, vecs[v].exp_cons, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wl);
        end

        // Reset after two of three words, with a byte of the third on offer.
        q = '{32'd3, 32'hCAFEF00D, 32'h0BADC0DE};
        wr_q.delete();
        do_start();
        send_stream(q, 0, cons, ncyc);
        chk("partial_consumed", cons, 12);
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_vals();
        repeat (6) @(posedge clk);
        #1;
        chk("idle_ready", byte_ready, 0);
        byte_valid = 1'b0;
        chk("partial_writes", wr_q.size(), 2);

        // Restart from IDLE, then relaunch from DONE.
        q = '{32'd3, 32'h11223344, 32'hA0000005, 32'hFFFFFFFF, 32'h4EDDCCBE};
        model(q, cons, d, e, wl);
        run(q, 0, cons, d, e, wl);
        model(q, cons, d, e, wl);
        run(q, 0, cons, d, e, wl);

        // Randomized streams.
        for (int it = 0; it < 12; it++) begin
            logic [31:0] n;
            logic [31:0] cs;
            q.delete();
            if ($urandom_range(7, 0) == 0) begin
                n = 32'd1025 + $urandom_range(100000, 0);
                q.push_back(n);
                q.push_back($urandom);
            end else begin
                n = $urandom_range(12, 0);
                q.push_back(n);
                cs = 32'd0;
                for (int k = 0; k < int'(n); k++) begin
                    q.push_back($urandom);
                    cs ^= q[k + 1];
                end
                if ($urandom_range(2, 0) == 0) cs ^= ($urandom | 32'd1);
                q.push_back(cs);
            end
            model(q, cons, d, e, wl);
            run(q, 30, cons, d, e, wl);
        end

        // Largest legal program fills the whole memory.
        begin
            logic [31:0] cs;
            q.delete();
            q.push_back(32'(MAXW));
            cs = 32'd0;
            for (int k = 0; k < MAXW; k++) begin
                q.push_back($urandom);
                cs ^= q[k + 1];
            end
            q.push_back(cs);
            model(q, cons, d, e, wl);
            run(q, 0, cons, d, e, wl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
